// File: rtl/transmitter_encoder_8b10b.sv
// Registered 8b/10b encoder with running-disparity tracking and illegal K-code substitution.
// Optional input register stage; output symbol, RD and error flag are all registered.
module transmitter_encoder_8b10b #(
    parameter bit RD_INIT   = 1'b0,
    parameter bit REG_INPUT = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_arst,
    input  logic       i_valid,
    input  logic       i_k_en,
    input  logic [7:0] i_byte,
    output logic       o_valid,
    output logic [9:0] o_symbol,
    output logic       o_rd,
    output logic       o_code_err
);

    localparam logic [9:0] RST_SYM = RD_INIT ? 10'h305 : 10'h0FA;

    // RD- column of the 5b/6b table (abcdei); the RD+ column is derived from it
    function automatic logic [5:0] enc6_neg(input logic [4:0] x);
        logic [5:0] c;
        case (x)
            5'd0:  c = 6'b100111;
            5'd1:  c = 6'b011101;
            5'd2:  c = 6'b101101;
            5'd3:  c = 6'b110001;
            5'd4:  c = 6'b110101;
            5'd5:  c = 6'b101001;
            5'd6:  c = 6'b011001;
            5'd7:  c = 6'b111000;
            5'd8:  c = 6'b111001;
            5'd9:  c = 6'b100101;
            5'd10: c = 6'b010101;
            5'd11: c = 6'b110100;
            5'd12: c = 6'b001101;
            5'd13: c = 6'b101100;
            5'd14: c = 6'b011100;
            5'd15: c = 6'b010111;
            5'd16: c = 6'b011011;
            5'd17: c = 6'b100011;
            5'd18: c = 6'b010011;
            5'd19: c = 6'b110010;
            5'd20: c = 6'b001011;
            5'd21: c = 6'b101010;
            5'd22: c = 6'b011010;
            5'd23: c = 6'b111010;
            5'd24: c = 6'b110011;
            5'd25: c = 6'b100110;
            5'd26: c = 6'b010110;
            5'd27: c = 6'b110110;
            5'd28: c = 6'b001110;
            5'd29: c = 6'b101110;
            5'd30: c = 6'b011110;
            default: c = 6'b101011;
        endcase
        return c;
    endfunction

    // RD- column of the 3b/4b table (fghj), primary P7 for y=7
    function automatic logic [3:0] enc4_neg(input logic [2:0] y);
        logic [3:0] c;
        case (y)
            3'd0:    c = 4'b1011;
            3'd1:    c = 4'b1001;
            3'd2:    c = 4'b0101;
            3'd3:    c = 4'b1100;
            3'd4:    c = 4'b1101;
            3'd5:    c = 4'b1010;
            3'd6:    c = 4'b0110;
            default: c = 4'b1110;
        endcase
        return c;
    endfunction

    logic       enc_vld;
    logic       enc_k;
    logic [7:0] enc_byte;

    generate
        if (REG_INPUT) begin : g_in_reg
            logic       vld_in_q;
            logic       k_in_q;
            logic [7:0] byte_in_q;

            always_ff @(posedge i_clk or posedge i_arst) begin
                if (i_arst) begin
                    vld_in_q  <= 1'b0;
                    k_in_q    <= 1'b0;
                    byte_in_q <= 8'h00;
                end else begin
                    vld_in_q  <= i_valid;
                    k_in_q    <= i_k_en;
                    byte_in_q <= i_byte;
                end
            end

            assign enc_vld  = vld_in_q;
            assign enc_k    = k_in_q;
            assign enc_byte = byte_in_q;
        end else begin : g_in_wire
            assign enc_vld  = i_valid;
            assign enc_k    = i_k_en;
            assign enc_byte = i_byte;
        end
    endgenerate

    logic       vld_q, rd_q, err_q;
    logic [9:0] sym_q;
    logic       rd_d, err_d;
    logic [9:0] sym_d;

    logic [4:0] xi, x;
    logic [2:0] yi, y;
    logic       k_legal, is_k28, rd6, alt7, six_unbal, four_unbal;
    logic [5:0] six_n, six;
    logic [3:0] four_n, four;

    always_comb begin
        xi      = enc_byte[4:0];
        yi      = enc_byte[7:5];
        k_legal = (xi == 5'd28) ||
                  ((yi == 3'd7) && ((xi == 5'd23) || (xi == 5'd27) ||
                                    (xi == 5'd29) || (xi == 5'd30)));
        err_d   = enc_k && !k_legal;
        x       = err_d ? 5'd28 : xi;
        y       = err_d ? 3'd5  : yi;
        is_k28  = enc_k && (x == 5'd28);

        six_n     = is_k28 ? 6'b001111 : enc6_neg(x);
        six_unbal = ($countones(six_n) != 3);
        // D.07 is balanced yet still has distinct RD- and RD+ forms
        six       = (rd_q && (six_unbal || (x == 5'd7))) ? ~six_n : six_n;
        rd6       = rd_q ^ six_unbal;

        alt7 = (y == 3'd7) &&
               (enc_k ||
                (!rd6 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                ( rd6 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));
        four_n     = alt7 ? 4'b0111 : enc4_neg(y);
        four_unbal = ($countones(four_n) != 2);
        four       = (rd6 && (four_unbal || (y == 3'd3))) ? ~four_n : four_n;
        // K28 takes the opposite form of balanced 4b codes to place the comma correctly
        if (is_k28 && !rd6 && !four_unbal && (y != 3'd3)) begin
            four = ~four_n;
        end

        rd_d  = rd6 ^ four_unbal;
        sym_d = {six, four};
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            vld_q <= 1'b0;
            sym_q <= RST_SYM;
            rd_q  <= RD_INIT;
            err_q <= 1'b0;
        end else begin
            vld_q <= enc_vld;
            if (enc_vld) begin
                sym_q <= sym_d;
                rd_q  <= rd_d;
                err_q <= err_d;
            end
        end
    end

    assign o_valid    = vld_q;
    assign o_symbol   = sym_q;
    assign o_rd       = rd_q;
    assign o_code_err = err_q;

endmodule

// File: tb/tb_transmitter_encoder_8b10b.sv
// Directed and table-driven self-checking bench for transmitter_encoder_8b10b.
// Reference model holds both RD columns explicitly and tracks RD from symbol weight.
module tb_transmitter_encoder_8b10b;

    logic       i_clk = 1'b0;
    logic       i_arst;
    logic       i_valid;
    logic       i_k_en;
    logic [7:0] i_byte;
    logic       o_valid;
    logic [9:0] o_symbol;
    logic       o_rd;
    logic       o_code_err;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic       m_rd;
    logic [9:0] last_sym;
    logic       last_err;

    always #5 i_clk = ~i_clk;

    transmitter_encoder_8b10b #(.RD_INIT(1'b0), .REG_INPUT(1'b0)) dut (
        .i_clk      (i_clk),
        .i_arst     (i_arst),
        .i_valid    (i_valid),
        .i_k_en     (i_k_en),
        .i_byte     (i_byte),
        .o_valid    (o_valid),
        .o_symbol   (o_symbol),
        .o_rd       (o_rd),
        .o_code_err (o_code_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {RD- code, RD+ code} for each 5b value, abcdei
    function automatic logic [11:0] t6(input logic [4:0] x);
        case (x)
            5'd0:  return {6'b100111, 6'b011000};
            5'd1:  return {6'b011101, 6'b100010};
            5'd2:  return {6'b101101, 6'b010010};
            5'd3:  return {6'b110001, 6'b110001};
            5'd4:  return {6'b110101, 6'b001010};
            5'd5:  return {6'b101001, 6'b101001};
            5'd6:  return {6'b011001, 6'b011001};
            5'd7:  return {6'b111000, 6'b000111};
            5'd8:  return {6'b111001, 6'b000110};
            5'd9:  return {6'b100101, 6'b100101};
            5'd10: return {6'b010101, 6'b010101};
            5'd11: return {6'b110100, 6'b110100};
            5'd12: return {6'b001101, 6'b001101};
            5'd13: return {6'b101100, 6'b101100};
            5'd14: return {6'b011100, 6'b011100};
            5'd15: return {6'b010111, 6'b101000};
            5'd16: return {6'b011011, 6'b100100};
            5'd17: return {6'b100011, 6'b100011};
            5'd18: return {6'b010011, 6'b010011};
            5'd19: return {6'b110010, 6'b110010};
            5'd20: return {6'b001011, 6'b001011};
            5'd21: return {6'b101010, 6'b101010};
            5'd22: return {6'b011010, 6'b011010};
            5'd23: return {6'b111010, 6'b000101};
            5'd24: return {6'b110011, 6'b001100};
            5'd25: return {6'b100110, 6'b100110};
            5'd26: return {6'b010110, 6'b010110};
            5'd27: return {6'b110110, 6'b001001};
            5'd28: return {6'b001110, 6'b001110};
            5'd29: return {6'b101110, 6'b010001};
            5'd30: return {6'b011110, 6'b100001};
            default: return {6'b101011, 6'b010100};
        endcase
    endfunction

    // {RD- code, RD+ code} for D.x.y 4b, indexed by RD after the 6b block
    function automatic logic [7:0] t4d(input logic [2:0] y);
        case (y)
            3'd0: return {4'b1011, 4'b0100};
            3'd1: return {4'b1001, 4'b1001};
            3'd2: return {4'b0101, 4'b0101};
            3'd3: return {4'b1100, 4'b0011};
            3'd4: return {4'b1101, 4'b0010};
            3'd5: return {4'b1010, 4'b1010};
            3'd6: return {4'b0110, 4'b0110};
            default: return {4'b1110, 4'b0001};
        endcase
    endfunction

    function automatic logic [7:0] t4k28(input logic [2:0] y);
        case (y)
            3'd0: return {4'b1011, 4'b0100};
            3'd1: return {4'b0110, 4'b1001};
            3'd2: return {4'b1010, 4'b0101};
            3'd3: return {4'b1100, 4'b0011};
            3'd4: return {4'b1101, 4'b0010};
            3'd5: return {4'b0101, 4'b1010};
            3'd6: return {4'b1001, 4'b0110};
            default: return {4'b0111, 4'b1000};
        endcase
    endfunction

    // returns {err, rd_after, symbol}
    function automatic logic [11:0] model(input logic rd, input logic k, input logic [7:0] b);
        logic [4:0]  x;
        logic [2:0]  y;
        logic        err, legal, r6, a7;
        logic [11:0] c6;
        logic [7:0]  c4;
        logic [5:0]  s6;
        logic [3:0]  s4;
        int          n;
        x = b[4:0];
        y = b[7:5];
        legal = (x == 5'd28) || ((y == 3'd7) &&
                ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30)));
        err = k && !legal;
        if (err) begin
            x = 5'd28;
            y = 3'd5;
        end
        c6 = (k && x == 5'd28) ? {6'b001111, 6'b110000} : t6(x);
        s6 = rd ? c6[5:0] : c6[11:6];
        n  = $countones(s6);
        r6 = (n == 3) ? rd : (n > 3);
        a7 = (y == 3'd7) && (k || (!r6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                                  ( r6 && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
        if (k && x == 5'd28) c4 = t4k28(y);
        else if (a7)         c4 = {4'b0111, 4'b1000};
        else                 c4 = t4d(y);
        s4 = r6 ? c4[3:0] : c4[7:4];
        n  = $countones(s4);
        return {err, (n == 2) ? r6 : (n > 2), s6, s4};
    endfunction

    task automatic check_out(input string tag, input logic [9:0] esym, input logic erd,
                             input logic eerr);
        int ones;
        chk({tag, ".sym"}, {22'd0, o_symbol}, {22'd0, esym});
        chk({tag, ".rd"}, {31'd0, o_rd}, {31'd0, erd});
        chk({tag, ".err"}, {31'd0, o_code_err}, {31'd0, eerr});
        chk({tag, ".vld"}, {31'd0, o_valid}, 32'd1);
        ones = $countones(o_symbol);
        chk({tag, ".disp"}, {31'd0, (ones >= 4 && ones <= 6)}, 32'd1);
        chk({tag, ".rdtrk"}, {31'd0, o_rd},
            {31'd0, (ones == 5) ? m_rd : (ones > 5)});
        m_rd     = erd;
        last_sym = esym;
        last_err = eerr;
    endtask

    task automatic drive(input logic k, input logic [7:0] b);
        i_valid = 1'b1;
        i_k_en  = k;
        i_byte  = b;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic dir(input string tag, input logic k, input logic [7:0] b,
                       input logic [9:0] esym, input logic erd, input logic eerr);
        drive(k, b);
        check_out(tag, esym, erd, eerr);
    endtask

    task automatic send(input logic k, input logic [7:0] b);
        logic [11:0] e;
        e = model(m_rd, k, b);
        drive(k, b);
        check_out($sformatf("%s%0d.%0d", k ? "K" : "D", b[4:0], b[7:5]), e[9:0], e[10], e[11]);
    endtask

    task automatic idle();
        i_valid = 1'b0;
        i_k_en  = 1'($urandom_range(0, 1));
        i_byte  = 8'($urandom_range(0, 255));
        @(posedge i_clk);
        #1;
        chk("idle.vld", {31'd0, o_valid}, 32'd0);
        chk("idle.sym", {22'd0, o_symbol}, {22'd0, last_sym});
        chk("idle.rd", {31'd0, o_rd}, {31'd0, m_rd});
        chk("idle.err", {31'd0, o_code_err}, {31'd0, last_err});
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".sym"}, {22'd0, o_symbol}, 32'h0FA);
        chk({tag, ".rd"}, {31'd0, o_rd}, 32'd0);
        chk({tag, ".vld"}, {31'd0, o_valid}, 32'd0);
        chk({tag, ".err"}, {31'd0, o_code_err}, 32'd0);
    endtask

    localparam logic [7:0] KLIST [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
                                          8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

    initial begin
        i_arst  = 1'b1;
        i_valid = 1'b0;
        i_k_en  = 1'b0;
        i_byte  = 8'h00;
        m_rd    = 1'b0;
        last_sym = 10'h0FA;
        last_err = 1'b0;
        #12;
        check_reset("rst_hold");
        @(posedge i_clk);
        #2;
        i_arst = 1'b0;
        @(posedge i_clk);
        #1;
        check_reset("rst_rel");

        dir("comma0", 1'b1, 8'hBC, 10'h0FA, 1'b1, 1'b0);
        dir("comma1", 1'b1, 8'hBC, 10'h305, 1'b0, 1'b0);
        dir("comma2", 1'b1, 8'hBC, 10'h0FA, 1'b1, 1'b0);
        dir("comma3", 1'b1, 8'hBC, 10'h305, 1'b0, 1'b0);
        dir("d0.0a", 1'b0, 8'h00, 10'h274, 1'b0, 1'b0);
        dir("d0.0b", 1'b0, 8'h00, 10'h274, 1'b0, 1'b0);
        dir("d21.5", 1'b0, 8'hB5, 10'h2AA, 1'b0, 1'b0);
        dir("d17.7", 1'b0, 8'hF1, 10'h237, 1'b1, 1'b0);
        dir("d11.7", 1'b0, 8'hEB, 10'h348, 1'b0, 1'b0);
        dir("illk0", 1'b1, 8'h00, 10'h0FA, 1'b1, 1'b1);
        dir("illk1", 1'b1, 8'h01, 10'h305, 1'b0, 1'b1);
        dir("k28.5", 1'b1, 8'hBC, 10'h0FA, 1'b1, 1'b0);
        idle();

        for (int v = 0; v < 256; v++) begin
            if (v == 128) begin
                drive(1'b0, 8'h55);
                #2;
                i_arst = 1'b1;
                #1;
                check_reset("rst_mid");
                @(posedge i_clk);
                #2;
                i_arst   = 1'b0;
                m_rd     = 1'b0;
                last_sym = 10'h0FA;
                last_err = 1'b0;
                idle();
            end
            if ($urandom_range(0, 3) == 0) idle();
            send(1'b0, 8'(v));
        end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 12; i++) begin
                if ($urandom_range(0, 3) == 0) idle();
                send(1'b1, KLIST[i]);
            end
        end
        for (int i = 0; i < 6; i++) send(1'b1, 8'($urandom_range(0, 255)));
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/transmitter_encoder_8b10b.md
# transmitter_encoder_8b10b

Registered 8b/10b line encoder with running-disparity tracking. It sits directly downstream of the transmitter packet generator: it consumes the generator's `o_phys_k_en` and `o_phys_byte` pair every cycle and produces the 10-bit DC-balanced symbol for the serializer. It validates K-codes, keeps running disparity (RD) across symbols, and flags illegal control requests.

## Interface
- `RD_INIT`, default 0: running disparity after reset. 0 means RD−, 1 means RD+.
- `REG_INPUT`, default 0: 1 adds an input register stage, raising latency from 1 to 2 cycles.
- `i_clk` in 1: single clock; all logic on its rising edge.
- `i_arst` in 1: asynchronous, active-high reset.
- `i_valid` in 1: input symbol strobe; tie to 1 behind the packet generator.
- `i_k_en` in 1: 1 encodes `i_byte` as a K-code, 0 as a D-code.
- `i_byte` in 8: HGF EDCBA. Bits [4:0] are x (5b part), bits [7:5] are y (3b part).
- `o_valid` out 1: `o_symbol` holds a newly encoded symbol this cycle.
- `o_symbol` out 10: encoded symbol, {a,b,c,d,e,i,f,g,h,j}. Bit 9 = a and is serialized first.
- `o_rd` out 1: RD after `o_symbol`. 1 means RD+.
- `o_code_err` out 1: the symbol in `o_symbol` replaced an illegal K request.

## Operation
- **Legal K-codes:** K28.0–K28.7, K23.7, K27.7, K29.7, K30.7.
  - Any other value with `i_k_en`=1 is illegal.
  - An illegal request is encoded as K28.5 at the current RD, with `o_code_err`=1 in the same cycle as that symbol.
- **Sub-blocks:** encoding splits into 5b/6b (abcdei) and 3b/4b (fghj). RD is evaluated per sub-block:
  - The 6b code is chosen by the RD entering the symbol.
  - The 4b code is chosen by the RD after the 6b sub-block.
  - Unbalanced sub-blocks (±2) flip RD. Neutral sub-blocks keep RD.
  - Exceptions: D.07 (111000/000111) and D/K.x.3 (1100/0011) are neutral but RD-dependent; they keep RD.
- **Alternate D.x.7 (A7 = 0111/1000)** is used instead of P7 when:
  - RD− and x ∈ {17,18,20}, or
  - RD+ and x ∈ {11,13,14}.
  - K.x.7 always uses A7.
- **K28.y 4b:** uses the RD-alternate column so that comma K28.1, K28.5 and K28.7 contain the singular comma.
- **Table source:** the encoding tables are the standard IBM Widmer–Franaszek tables. No table entry is left undefined.
- **Input with `i_valid`=0:** no update. `o_symbol`, `o_rd` and `o_code_err` hold their values. `o_valid`=0.
- **RD state:** one flip-flop `rd`. It updates only when a symbol is encoded and is output as `o_rd`.
- **`REG_INPUT`=1:** an input register captures `i_valid`, `i_k_en` and `i_byte`; the encoder then operates on the registered copy.
- **Size:** about 200 RTL lines (case tables plus disparity logic).

## Timing
- **Latency:** 1 cycle from input to `o_symbol` (2 cycles with `REG_INPUT`=1). Throughput is one symbol per cycle with no back-pressure.
- **Reset values (immediate on `i_arst`, independent of clock):**
  - `rd` = `RD_INIT`.
  - `o_symbol` = K28.5 at `RD_INIT`: 0x0FA if RD−, 0x305 if RD+.
  - `o_valid`=0, `o_code_err`=0, `o_rd`=`RD_INIT`.
  - The `REG_INPUT` stage clears to valid=0.
- **Reset mid-stream:** any in-flight symbol is discarded. The first symbol after release is encoded with `RD_INIT`.
- **Error flag:** `o_code_err` is a one-cycle pulse per illegal symbol. Back-to-back illegal inputs hold it high.
- **Timing closure:** no combinational path from inputs to outputs. The critical path (6b select, then 4b select, then RD) must close at the link byte clock.

## Test plan
- **Reset:** `RD_INIT`=0, assert then release `i_arst` → `o_symbol`=0x0FA, `o_rd`=0, `o_valid`=0, `o_code_err`=0.
- **Comma alternation:** three consecutive K28.5 (`i_k_en`=1, `i_byte`=0xBC) → `o_symbol` = 0x0FA, 0x305, 0x0FA; `o_rd` = 1, 0, 1.
- **Balanced D-codes:** D0.0 (0x00) repeated from RD− → every symbol 0x274, `o_rd` stays 0. D21.5 (0xB5) → 0x2AA, RD unchanged.
- **A7 selection:** from RD−, D17.7 (0xF1) → 6b 100011, 4b 0111 (A7), symbol 0x237. From RD+, D11.7 (0xEB) → 6b 110100, 4b 1000 (A7), symbol 0x348.
- **Illegal K:** `i_k_en`=1, `i_byte`=0x00 → K28.5 at current RD, `o_code_err`=1 for exactly that cycle, RD advanced as for K28.5.
- **Exhaustive check:** all 256 D-codes and 12 K-codes, random `i_valid` gaps and one mid-stream reset → match a reference model. Every symbol has disparity 0 or ±2, and running disparity never exceeds ±1.
